// File: rtl/string_loader.sv
// string_loader: assembles a host string in a shadow buffer and commits it atomically to a comparator.
// Optional build macro STRING_LOADER_CHECKSUM_EN adds a trailing XOR checksum word before commit.
module string_loader #(
    parameter int MAX_LEN = 17,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4:0]              len_in,
    input  logic                    wr_en,
    input  logic [31:0]             wr_data,
    output logic                    ready,
    output logic                    busy,
    output logic [MAX_LEN-1:0][7:0] string_out,
    output logic [4:0]              strlen_out,
    output logic                    string_valid,
    output logic                    cmp_clear,
    output logic                    done,
    output logic                    error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     err_event;

    logic [4:0]               n_len;
    logic [2:0]               word_cnt;
    logic [2:0]               w_total;
    logic [7:0]               timer;
    logic [MAX_LEN-1:0][7:0]  shadow;
    logic [MAX_LEN-1:0][7:0]  shadow_next;
    logic [7:0]               csum;
    logic [7:0]               word_xor;

    logic                     len_ok;
    logic                     restart;
    logic                     word_take;

    assign len_ok    = (len_in != 5'd0) && (int'(len_in) <= MAX_LEN);
    assign restart   = start && (state != COMMIT) && len_ok;
    assign word_take = (state == LOAD) && wr_en && !start;
    assign w_total   = 3'((int'(n_len) + 3) / 4);

    assign ready = (state == LOAD);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_event  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_next = LOAD;
                    end else begin
                        err_event = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (start) begin
                    if (!len_ok) begin
                        state_next = IDLE;
                        err_event  = 1'b1;
                    end
                end else if (wr_en) begin
`ifdef STRING_LOADER_CHECKSUM_EN
                    if (word_cnt == w_total) begin
                        if (wr_data[7:0] == csum) begin
                            state_next = COMMIT;
                        end else begin
                            state_next = IDLE;
                            err_event  = 1'b1;
                        end
                    end
`else
                    if (word_cnt == w_total - 3'd1) begin
                        state_next = COMMIT;
                    end
`endif
                end else if (timer == 8'(TIMEOUT - 1)) begin
                    state_next = IDLE;
                    err_event  = 1'b1;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte k of the string lands at MAX_LEN-N+k; bytes past N in the last word are dropped.
    always_comb begin
        shadow_next = shadow;
        word_xor    = 8'h00;
        for (int j = 0; j < 4; j++) begin
            if (int'(word_cnt) * 4 + j < int'(n_len)) begin
                word_xor = word_xor ^ wr_data[31-8*j -: 8];
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (i == MAX_LEN - int'(n_len) + int'(word_cnt) * 4 + j) begin
                        shadow_next[i] = wr_data[31-8*j -: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_len    <= 5'd0;
            word_cnt <= 3'd0;
            timer    <= 8'd0;
            shadow   <= '0;
            csum     <= 8'h00;
        end else if (restart) begin
            n_len    <= len_in;
            word_cnt <= 3'd0;
            timer    <= 8'd0;
            shadow   <= '0;
            csum     <= 8'h00;
        end else if (word_take) begin
            timer <= 8'd0;
            if (word_cnt < w_total) begin
                shadow   <= shadow_next;
                csum     <= csum ^ word_xor;
                word_cnt <= word_cnt + 3'd1;
            end
        end else if (state == LOAD) begin
            timer <= timer + 8'd1;
        end
    end

    // Committed outputs only move on the COMMIT cycle so the comparator never sees a partial string.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            string_out   <= '0;
            strlen_out   <= 5'd0;
            string_valid <= 1'b0;
            cmp_clear    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            cmp_clear <= 1'b0;
            done      <= 1'b0;
            error     <= err_event;
            if (state == COMMIT) begin
                string_out   <= shadow;
                strlen_out   <= n_len;
                string_valid <= 1'b1;
                cmp_clear    <= 1'b1;
                done         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_string_loader.sv
// Randomized self-checking bench for string_loader against a byte-queue reference model.
// Honours STRING_LOADER_CHECKSUM_EN the same way the design does.
module tb_string_loader;

    localparam int MAX_LEN = 17;
    localparam int TIMEOUT = 255;
    localparam int SW      = MAX_LEN * 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [4:0]              len_in = 5'd0;
    logic                    wr_en = 1'b0;
    logic [31:0]             wr_data = 32'd0;
    logic                    ready;
    logic                    busy;
    logic [MAX_LEN-1:0][7:0] string_out;
    logic [4:0]              strlen_out;
    logic                    string_valid;
    logic                    cmp_clear;
    logic                    done;
    logic                    error;

    string_loader #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len_in(len_in),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .ready(ready),
        .busy(busy),
        .string_out(string_out),
        .strlen_out(strlen_out),
        .string_valid(string_valid),
        .cmp_clear(cmp_clear),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: a loading flag, the bytes received so far and the committed image.
    bit                      m_loading = 1'b0;
    bit                      m_commit  = 1'b0;
    bit                      m_valid   = 1'b0;
    bit                      m_done    = 1'b0;
    bit                      m_clear   = 1'b0;
    bit                      m_error   = 1'b0;
    int                      m_n       = 0;
    int                      m_words   = 0;
    int                      m_idle    = 0;
    logic [7:0]              m_bytes[$];
    logic [MAX_LEN-1:0][7:0] m_str     = '0;
    logic [4:0]              m_len     = 5'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading = 0; m_commit = 0; m_valid = 0;
            m_done = 0; m_clear = 0; m_error = 0;
            m_n = 0; m_words = 0; m_idle = 0;
            m_bytes.delete();
            m_str = '0; m_len = 5'd0;
        end else begin
            m_done = 0; m_clear = 0; m_error = 0;
            if (m_commit) begin
                m_str = '0;
                for (int k = 0; k < m_n; k++) m_str[MAX_LEN - m_n + k] = m_bytes[k];
                m_len = 5'(m_n);
                m_valid = 1; m_done = 1; m_clear = 1; m_commit = 0;
            end else if (start) begin
                if (int'(len_in) >= 1 && int'(len_in) <= MAX_LEN) begin
                    m_loading = 1; m_n = int'(len_in);
                    m_bytes.delete(); m_words = 0; m_idle = 0;
                end else begin
                    m_error = 1; m_loading = 0;
                end
            end else if (m_loading) begin
                if (wr_en) begin
                    m_idle = 0;
                    if (m_words < (m_n + 3) / 4) begin
                        for (int j = 0; j < 4; j++)
                            if (m_bytes.size() < m_n) m_bytes.push_back(wr_data[31-8*j -: 8]);
                        m_words++;
`ifndef STRING_LOADER_CHECKSUM_EN
                        if (m_words == (m_n + 3) / 4) begin
                            m_commit = 1; m_loading = 0;
                        end
`endif
                    end else begin
                        logic [7:0] x;
                        x = 8'h00;
                        foreach (m_bytes[k]) x = x ^ m_bytes[k];
                        if (wr_data[7:0] == x) m_commit = 1;
                        else m_error = 1;
                        m_loading = 0;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_error = 1; m_loading = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("ready",        SW'(ready),        SW'(m_loading));
            checkOutput("busy",         SW'(busy),         SW'(m_loading | m_commit));
            checkOutput("string_out",   SW'(string_out),   SW'(m_str));
            checkOutput("strlen_out",   SW'(strlen_out),   SW'(m_len));
            checkOutput("string_valid", SW'(string_valid), SW'(m_valid));
            checkOutput("cmp_clear",    SW'(cmp_clear),    SW'(m_clear));
            checkOutput("done",         SW'(done),         SW'(m_done));
            checkOutput("error",        SW'(error),        SW'(m_error));
        end
    end

    task automatic applyStimulus(input bit s, input logic [4:0] l, input bit w, input logic [31:0] d);
        @(negedge clk);
        start = s; len_in = l; wr_en = w; wr_data = d;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 5'd0, 1'b0, $urandom);
    endtask

    logic [7:0] tb_bytes[20];

    // Start, then the data words (random gaps), then the checksum word when that build is selected.
    task automatic send_load(input int len, input int gapmax, input bit corrupt);
        int nw;
        logic [7:0] x;
        nw = (len + 3) / 4;
        x = 8'h00;
        applyStimulus(1'b1, 5'(len), 1'b0, $urandom);
        for (int w = 0; w < nw; w++) begin
            repeat ($urandom_range(0, gapmax)) applyStimulus(1'b0, 5'd0, 1'b0, $urandom);
            applyStimulus(1'b0, 5'd0, 1'b1,
                          {tb_bytes[4*w], tb_bytes[4*w+1], tb_bytes[4*w+2], tb_bytes[4*w+3]});
        end
        for (int k = 0; k < len; k++) x = x ^ tb_bytes[k];
        if (corrupt) x = x ^ 8'h01;
`ifdef STRING_LOADER_CHECKSUM_EN
        applyStimulus(1'b0, 5'd0, 1'b1, {$urandom_range(0, 255) == 0 ? 24'h0 : 24'hABCDEF, x});
`endif
    endtask

    task automatic randomBytes();
        for (int k = 0; k < 20; k++) tb_bytes[k] = 8'($urandom);
    endtask

    logic [MAX_LEN-1:0][7:0] exp_str;
    logic [MAX_LEN-1:0][7:0] alpha_str;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_string", SW'(string_out), SW'(0));
        checkOutput("reset_strlen", SW'(strlen_out), SW'(0));
        checkOutput("reset_valid",  SW'(string_valid), SW'(0));
        checkOutput("reset_busy",   SW'({ready, busy, done, error, cmp_clear}), SW'(0));
        rst = 1'b0;
        checking = 1'b1;

        // "GET"
        randomBytes();
        tb_bytes[0] = 8'h47; tb_bytes[1] = 8'h45; tb_bytes[2] = 8'h54; tb_bytes[3] = 8'h00;
        send_load(3, 0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        exp_str = '0;
        exp_str[14] = 8'h47; exp_str[15] = 8'h45; exp_str[16] = 8'h54;
        checkOutput("get_string", SW'(string_out), SW'(exp_str));
        checkOutput("get_strlen", SW'(strlen_out), SW'(3));
        checkOutput("get_pulses", SW'({string_valid, cmp_clear, done}), SW'(3'b111));

`ifdef STRING_LOADER_CHECKSUM_EN
        send_load(3, 0, 1'b1);
        @(posedge clk); #1;
        checkOutput("bad_csum_pulses", SW'({error, cmp_clear, done, busy}), SW'(4'b1000));
        checkOutput("bad_csum_string", SW'(string_out), SW'(exp_str));
`endif

        // 17-byte load with gaps
        randomBytes();
        for (int k = 0; k < MAX_LEN; k++) tb_bytes[k] = 8'(8'h41 + k);
        send_load(17, 3, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < MAX_LEN; k++) alpha_str[k] = 8'(8'h41 + k);
        checkOutput("full_string", SW'(string_out), SW'(alpha_str));
        checkOutput("full_strlen", SW'(strlen_out), SW'(17));
        checkOutput("full_done",   SW'({done, ready}), SW'(2'b10));

        // Invalid lengths
        applyStimulus(1'b1, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("len0_error", SW'({error, busy}), SW'(2'b10));
        applyStimulus(1'b1, 5'd18, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("len18_error", SW'({error, busy}), SW'(2'b10));
        checkOutput("len18_hold", SW'(string_out), SW'(alpha_str));

        // Timeout after one word
        applyStimulus(1'b1, 5'd8, 1'b0, 32'd0);
        applyStimulus(1'b0, 5'd0, 1'b1, $urandom);
        idleCycles(TIMEOUT);
        @(posedge clk); #1;
        checkOutput("timeout_error", SW'({error, busy, done}), SW'(3'b100));
        checkOutput("timeout_hold",  SW'(string_out), SW'(alpha_str));

        // Restart mid-load with a 2-byte string; start beats the simultaneous word
        applyStimulus(1'b1, 5'd8, 1'b0, 32'd0);
        applyStimulus(1'b0, 5'd0, 1'b1, $urandom);
        idleCycles(100);
        applyStimulus(1'b1, 5'd2, 1'b1, 32'hDEADBEEF);
        applyStimulus(1'b0, 5'd0, 1'b1, 32'h5A5B1234);
`ifdef STRING_LOADER_CHECKSUM_EN
        applyStimulus(1'b0, 5'd0, 1'b1, 32'h00000001);
`endif
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        exp_str = '0;
        exp_str[15] = 8'h5A; exp_str[16] = 8'h5B;
        checkOutput("restart_string", SW'(string_out), SW'(exp_str));
        checkOutput("restart_strlen", SW'(strlen_out), SW'(2));

        // Reset while the third word of a 12-byte load is in flight
        randomBytes();
        applyStimulus(1'b1, 5'd12, 1'b0, 32'd0);
        applyStimulus(1'b0, 5'd0, 1'b1, $urandom);
        applyStimulus(1'b0, 5'd0, 1'b1, $urandom);
        applyStimulus(1'b0, 5'd0, 1'b1, $urandom);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_string", SW'(string_out), SW'(0));
        checkOutput("rst_flags",  SW'({strlen_out, string_valid, busy, ready, done}), SW'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; wr_en = 1'b0;
        randomBytes();
        send_load(5, 2, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("post_rst_load", SW'({strlen_out, string_valid}), SW'({5'd5, 1'b1}));

        // Randomized structured loads, some with a wrong checksum
        repeat (15) begin
            randomBytes();
            send_load($urandom_range(1, MAX_LEN), 4, ($urandom % 4) == 0);
            idleCycles($urandom_range(0, 3));
        end

        // Fully random input traffic
        repeat (600) begin
            applyStimulus(($urandom % 12) == 0, 5'($urandom_range(0, 19)), 1'($urandom % 2), $urandom);
        end
        idleCycles(4);

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
